// File: rtl/sseg_mux_nx.sv
// sseg_mux_nx: N-digit multiplexed seven-segment driver with shadow regs, blanking, PWM and ghost guard
module sseg_mux_nx #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [3:0]              brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    slot_tick
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [3:0]              pwm_cnt;
  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   blank;
  logic [3:0]              nib;
  logic [6:0]              dec;
  logic                    wrap, last, lit, nz;
  assign wrap = presc == PW'(REFRESH_DIV - 1);
  assign last = idx == IW'(NUM_DIGITS - 1);
  assign nib  = sh_val[{idx, 2'b00} +: 4];
  assign lit  = presc >= PW'(GUARD) && pwm_cnt < brightness && !blank[idx];
  // a digit blanks only when it and every more-significant digit carry neither a nibble nor a dp
  always_comb begin
    nz = 1'b0;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz = nz | (|sh_val[4*i +: 4]) | sh_dp[i];
      blank[i] = blank_lz && i != 0 && !nz;
    end
  end
  always_comb begin
    case (nib)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h10;
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      default: dec = 7'h0E;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      idx       <= '0;
      pwm_cnt   <= '0;
      sh_val    <= '0;
      sh_dp     <= '0;
      seg       <= 7'h7F;
      dp        <= 1'b1;
      an        <= '1;
      slot_tick <= 1'b0;
    end else begin
      presc   <= wrap ? '0 : presc + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (wrap) idx <= last ? '0 : idx + 1'b1;
      if (load) begin
        sh_val <= value;
        sh_dp  <= dp_in;
      end
      seg       <= blank[idx] ? 7'h7F : dec;
      dp        <= ~sh_dp[idx];
      an        <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
      slot_tick <= wrap;
    end
  end
endmodule

// File: tb/tb_sseg_mux_nx.sv
// tb_sseg_mux_nx: directed checks of scan order, decode, blanking, PWM, load timing and async reset
module tb_sseg_mux_nx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  brightness = 4'd15;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        slot_tick;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lows;

  sseg_mux_nx #(.NUM_DIGITS(4), .REFRESH_DIV(20), .GUARD(2)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .brightness(brightness), .seg(seg), .dp(dp), .an(an),
    .slot_tick(slot_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_digit(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp);
    chk({tag, "_an"}, 32'(an), 32'(e_an));
    chk({tag, "_seg"}, 32'(seg), 32'(e_seg));
    chk({tag, "_dp"}, 32'(dp), 32'(e_dp));
  endtask

  initial begin
    // reset held while inputs and load toggle
    @(negedge clk);
    value = 16'hFFFF; dp_in = 4'hF; load = 1'b1; blank_lz = 1'b1;
    step();
    value = 16'h5A5A; load = 1'b0;
    step();
    load = 1'b1;
    step();
    chk_digit("reset", 4'hF, 7'h7F, 1'b1);
    chk("reset_tick", 32'(slot_tick), 32'd0);
    // release and load 12AF in the same cycle
    cyc = 0;
    rst_n = 1'b1; value = 16'h12AF; dp_in = 4'h0; load = 1'b1; blank_lz = 1'b0; brightness = 4'd15;
    run_to(1);
    load = 1'b0;
    run_to(2);  chk("guard0", 32'(an), 32'hF);
    run_to(3);  chk_digit("d0_first_lit", 4'hE, 7'h0E, 1'b1);
    run_to(5);  chk_digit("d0_F", 4'hE, 7'h0E, 1'b1);
    run_to(16); chk("pwm15_off", 32'(an), 32'hF);
    run_to(17); chk("pwm15_on", 32'(an), 32'hE);
    run_to(19); chk("tick_before", 32'(slot_tick), 32'd0);
    run_to(20); chk("tick_first", 32'(slot_tick), 32'd1);
    run_to(21); chk("tick_after", 32'(slot_tick), 32'd0);
    chk("d1_guard_a", 32'(an), 32'hF);
    run_to(22); chk("d1_guard_b", 32'(an), 32'hF);
    run_to(23); chk("d1_first_lit", 32'(an), 32'hD);
    run_to(25); chk_digit("d1_A", 4'hD, 7'h08, 1'b1);
    run_to(45); chk_digit("d2_2", 4'hB, 7'h24, 1'b1);
    run_to(65); chk_digit("d3_1", 4'h7, 7'h79, 1'b1);
    run_to(81); chk("wrap_guard", 32'(an), 32'hF);
    run_to(85); chk_digit("d0_again", 4'hE, 7'h0E, 1'b1);
    // leading-zero blanking of 0040
    value = 16'h0040; dp_in = 4'h0; blank_lz = 1'b1; load = 1'b1;
    run_to(86);
    load = 1'b0;
    run_to(90);  chk_digit("lz_d0", 4'hE, 7'h40, 1'b1);
    run_to(105); chk_digit("lz_d1", 4'hD, 7'h19, 1'b1);
    run_to(125); chk_digit("lz_d2_blank", 4'hF, 7'h7F, 1'b1);
    run_to(145); chk_digit("lz_d3_blank", 4'hF, 7'h7F, 1'b1);
    dp_in = 4'b1000; load = 1'b1;
    run_to(146);
    load = 1'b0;
    run_to(150); chk_digit("dp_d3", 4'h7, 7'h40, 1'b0);
    run_to(165); chk_digit("dp_d0", 4'hE, 7'h40, 1'b1);
    run_to(185); chk_digit("dp_d1", 4'hD, 7'h19, 1'b1);
    run_to(205); chk_digit("dp_d2", 4'hB, 7'h40, 1'b1);
    // all-zero value: only digit 0 lights
    value = 16'h0000; dp_in = 4'h0; load = 1'b1;
    run_to(206);
    load = 1'b0;
    run_to(210); chk_digit("zero_d2", 4'hF, 7'h7F, 1'b1);
    run_to(225); chk_digit("zero_d3", 4'hF, 7'h7F, 1'b1);
    run_to(245); chk_digit("zero_d0", 4'hE, 7'h40, 1'b1);
    run_to(265); chk_digit("zero_d1", 4'hF, 7'h7F, 1'b1);
    // brightness 4: four lit cycles per 16-cycle window
    brightness = 4'd4;
    run_to(322);
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (an != 4'hF) lows++;
    end
    chk("pwm4_window", 32'(lows), 32'd4);
    run_to(340);
    brightness = 4'd0;
    lows = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (an != 4'hF) lows++;
    end
    chk("pwm0_dark", 32'(lows), 32'd0);
    // value change without load is ignored
    value = 16'h3210; load = 1'b1; brightness = 4'd15; blank_lz = 1'b0;
    run_to(421);
    load = 1'b0; value = 16'hFFFF;
    run_to(425); chk_digit("noload_d1", 4'hD, 7'h79, 1'b1);
    // load on the wrap edge lands in the new slot
    run_to(439);
    value = 16'h0700; load = 1'b1;
    run_to(440);
    load = 1'b0;
    chk_digit("prewrap_d1", 4'hD, 7'h79, 1'b1);
    chk("wrap_tick", 32'(slot_tick), 32'd1);
    run_to(441); chk("wrap_newseg", 32'(seg), 32'h78);
    run_to(445); chk_digit("wrap_d2_7", 4'hB, 7'h78, 1'b1);
    // async reset mid-slot
    #1 rst_n = 1'b0;
    #1 chk_digit("async_rst", 4'hF, 7'h7F, 1'b1);
    step();
    step();
    cyc = 0;
    rst_n = 1'b1;
    run_to(5);  chk_digit("restart_d0", 4'hE, 7'h40, 1'b1);
    run_to(19); chk("restart_tick0", 32'(slot_tick), 32'd0);
    run_to(20); chk("restart_tick1", 32'(slot_tick), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
